// File: rtl/osd_text_overlay_if.sv
`default_nettype none
// ============================================================================
// Module   : osd_text_overlay_if
// Brief    : Video taps, CPU char-buffer bus, font ROM port and mixed output
// Revision : 1.0
// ============================================================================
interface osd_text_overlay_if;
  logic       ce;
  logic [9:0] osd_hcnt;
  logic [8:0] osd_vcnt;
  logic       osd_paper;
  logic       osd_blink;
  logic [4:0] in_red;
  logic [4:0] in_grn;
  logic [4:0] in_blu;
  logic       wr;
  logic       ctrl_wr;
  logic [7:0] addr;
  logic [7:0] d;
  logic [9:0] font_addr;
  logic [7:0] font_data;
  logic [4:0] out_red;
  logic [4:0] out_grn;
  logic [4:0] out_blu;
  logic       busy;

  modport master (
    output ce, osd_hcnt, osd_vcnt, osd_paper, osd_blink,
    output in_red, in_grn, in_blu, wr, ctrl_wr, addr, d, font_data,
    input  font_addr, out_red, out_grn, out_blu, busy
  );

  modport slave (
    input  ce, osd_hcnt, osd_vcnt, osd_paper, osd_blink,
    input  in_red, in_grn, in_blu, wr, ctrl_wr, addr, d, font_data,
    output font_addr, out_red, out_grn, out_blu, busy
  );
endinterface
`default_nettype wire

// File: rtl/osd_text_overlay.sv
`default_nettype none
// ============================================================================
// Module   : osd_text_overlay
// Brief    : 32x8 char text window mixed over 5:5:5 video, fixed 3-ce latency
// Revision : 1.0
// ============================================================================
module osd_text_overlay #(
  parameter logic [9:0]  X0       = 10'd32,
  parameter logic [8:0]  Y0       = 9'd96,
  parameter logic [14:0] FG_COLOR = 15'h7FE0
) (
  input logic               clk,
  input logic               res,
  osd_text_overlay_if.slave bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [7:0] C_BLANK = 8'h20;

  logic [7:0] mem [0:255];
  logic [7:0] ram_rd_q;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       en_q, en_d;

  logic        hit1_q, hit1_d;
  logic [2:0]  bit1_q, bit1_d;
  logic [2:0]  line1_q, line1_d;
  logic        blink1_q, blink1_d;
  logic [14:0] rgb1_q, rgb1_d;

  logic        hit2_q, hit2_d;
  logic [2:0]  bit2_q, bit2_d;
  logic        attr2_q, attr2_d;
  logic        blink2_q, blink2_d;
  logic [14:0] rgb2_q, rgb2_d;

  logic [9:0]  font_addr_q, font_addr_d;
  logic [14:0] out_q, out_d;

  logic [9:0] w_dx;
  logic [8:0] w_dy;
  logic       w_hit;
  logic [7:0] w_rd_addr;
  logic       w_mem_we;
  logic [7:0] w_mem_wa;
  logic [7:0] w_mem_wd;
  logic       w_pix_on;

  // Unsigned wrap makes positions left/above the window land far out of range.
  assign w_dx      = bus.osd_hcnt - X0;
  assign w_dy      = bus.osd_vcnt - Y0;
  assign w_hit     = bus.osd_paper & en_q & (w_dx[9:8] == 2'b00) & (w_dy[8:6] == 3'b000);
  assign w_rd_addr = {w_dy[5:3], w_dx[7:3]};

  assign w_mem_we = busy_q | bus.wr;
  assign w_mem_wa = busy_q ? cnt_q   : bus.addr;
  assign w_mem_wd = busy_q ? C_BLANK : bus.d;

  assign w_pix_on = bus.font_data[3'd7 - bit2_q] ^ (attr2_q & blink2_q);

  // Character buffer: no reset, old data on read-during-write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_mem_wa] <= w_mem_wd;
    end
    if (bus.ce) begin
      ram_rd_q <= mem[w_rd_addr];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    en_d    = en_q;
    if (bus.ctrl_wr) begin
      en_d = bus.d[0];
    end
    case (state_q)
      IDLE: begin
        if (bus.ctrl_wr && bus.d[1]) begin
          state_d = CLEAR;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (bus.ctrl_wr && bus.d[1]) begin
          cnt_d = 8'd0;
        end else if (cnt_q == 8'hFF) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    hit1_d      = hit1_q;
    bit1_d      = bit1_q;
    line1_d     = line1_q;
    blink1_d    = blink1_q;
    rgb1_d      = rgb1_q;
    hit2_d      = hit2_q;
    bit2_d      = bit2_q;
    attr2_d     = attr2_q;
    blink2_d    = blink2_q;
    rgb2_d      = rgb2_q;
    font_addr_d = font_addr_q;
    out_d       = out_q;
    if (bus.ce) begin
      hit1_d      = w_hit;
      bit1_d      = w_dx[2:0];
      line1_d     = w_dy[2:0];
      blink1_d    = bus.osd_blink;
      rgb1_d      = {bus.in_red, bus.in_grn, bus.in_blu};
      font_addr_d = {ram_rd_q[6:0], line1_q};
      attr2_d     = ram_rd_q[7];
      hit2_d      = hit1_q;
      bit2_d      = bit1_q;
      blink2_d    = blink1_q;
      rgb2_d      = rgb1_q;
      if (!hit2_q) begin
        out_d = rgb2_q;
      end else if (w_pix_on) begin
        out_d = FG_COLOR;
      end else begin
        out_d = {1'b0, rgb2_q[14:11], 1'b0, rgb2_q[9:6], 1'b0, rgb2_q[4:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      hit1_q      <= 1'b0;
      bit1_q      <= 3'd0;
      line1_q     <= 3'd0;
      blink1_q    <= 1'b0;
      rgb1_q      <= 15'd0;
      hit2_q      <= 1'b0;
      bit2_q      <= 3'd0;
      attr2_q     <= 1'b0;
      blink2_q    <= 1'b0;
      rgb2_q      <= 15'd0;
      font_addr_q <= 10'd0;
      out_q       <= 15'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      hit1_q      <= hit1_d;
      bit1_q      <= bit1_d;
      line1_q     <= line1_d;
      blink1_q    <= blink1_d;
      rgb1_q      <= rgb1_d;
      hit2_q      <= hit2_d;
      bit2_q      <= bit2_d;
      attr2_q     <= attr2_d;
      blink2_q    <= blink2_d;
      rgb2_q      <= rgb2_d;
      font_addr_q <= font_addr_d;
      out_q       <= out_d;
    end
  end

  assign bus.font_addr = font_addr_q;
  assign bus.out_red   = out_q[14:10];
  assign bus.out_grn   = out_q[9:5];
  assign bus.out_blu   = out_q[4:0];
  assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_osd_text_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_osd_text_overlay
// Brief    : Directed self-checking bench for the text OSD mixer
// Revision : 1.0
// ============================================================================
module tb_osd_text_overlay;
  logic clk = 1'b0;
  logic res;
  int   total = 0;
  int   bad   = 0;

  osd_text_overlay_if bus();

  osd_text_overlay #(
    .X0       (10'd32),
    .Y0       (9'd96),
    .FG_COLOR (15'h7FE0)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Font ROM: glyph 0x41 has a left dot on line 0 and a right dot on line 7.
  function automatic logic [7:0] font_rom(input logic [9:0] a);
    logic [6:0] code;
    logic [2:0] line;
    code = a[9:3];
    line = a[2:0];
    if (code == 7'h41 && line == 3'd0) return 8'h80;
    if (code == 7'h41 && line == 3'd7) return 8'h01;
    return 8'h00;
  endfunction

  always @(posedge clk) bus.font_data <= font_rom(bus.font_addr);

  function automatic logic [14:0] rgb(input int r, input int g, input int b);
    return {5'(r), 5'(g), 5'(b)};
  endfunction

  function automatic logic [14:0] cur_out();
    return {bus.out_red, bus.out_grn, bus.out_blu};
  endfunction

  task automatic set_pix(input logic [9:0] h, input logic [8:0] v, input logic p,
                         input logic bl, input logic [14:0] c);
    bus.osd_hcnt  = h;
    bus.osd_vcnt  = v;
    bus.osd_paper = p;
    bus.osd_blink = bl;
    {bus.in_red, bus.in_grn, bus.in_blu} = c;
  endtask

  task automatic step_ce();
    bus.ce = 1'b1;
    @(posedge clk); #1;
    bus.ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] v);
    bus.wr   = 1'b1;
    bus.addr = a;
    bus.d    = v;
    @(posedge clk); #1;
    bus.wr   = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    bus.ctrl_wr = 1'b1;
    bus.d       = v;
    @(posedge clk); #1;
    bus.ctrl_wr = 1'b0;
  endtask

  task automatic run_pixel(input logic [9:0] h, input logic [8:0] v, input logic p,
                           input logic bl, input logic [14:0] c,
                           output logic [14:0] o, output logic [9:0] fa);
    set_pix(h, v, p, bl, c);
    repeat (3) step_ce();
    o  = cur_out();
    fa = bus.font_addr;
  endtask

  task automatic run_stream(input logic [9:0] h0, input logic [8:0] v, input logic bl,
                            input logic [14:0] c,
                            output logic [7:0][14:0] outs, output logic [9:0] fa0);
    outs = '0;
    fa0  = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_pix(h0 + 10'(i), v, 1'b1, bl, c);
      else       set_pix(10'd0, v, 1'b0, bl, c);
      step_ce();
      if (i == 1) fa0 = bus.font_addr;
      if (i >= 2) outs[i-2] = cur_out();
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cur_out() !== 15'd0) begin
      bad++; $display("FAIL reset_out: got %h want %h", cur_out(), 15'd0);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    total++;
    if (bus.font_addr !== 10'd0) begin
      bad++; $display("FAIL reset_font_addr: got %h want 000", bus.font_addr);
    end
    res = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [14:0] vals [6];
    logic [9:0]  hs   [6];
    logic [14:0] exp_o;
    vals = '{rgb(20,10,4), rgb(1,2,3), rgb(31,31,31), rgb(0,17,9), rgb(20,10,4), rgb(5,6,7)};
    hs   = '{10'd32, 10'd33, 10'd100, 10'd0, 10'd500, 10'd287};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) set_pix(hs[i], 9'd96, 1'b1, 1'b0, vals[i]);
      step_ce();
      exp_o = (i >= 2) ? vals[i-2] : 15'd0;
      total++;
      if (cur_out() !== exp_o) begin
        bad++; $display("FAIL passthrough_ce%0d: got %h want %h", i, cur_out(), exp_o);
      end
    end
  endtask

  task automatic test_overlay_text();
    logic [7:0][14:0] outs;
    logic [9:0]       fa0;
    logic [14:0]      exp_o;
    cpu_write(8'd0, 8'h41);
    ctrl_write(8'h01);
    run_stream(10'd32, 9'd96, 1'b0, rgb(20,10,4), outs, fa0);
    total++;
    if (fa0 !== {7'h41, 3'd0}) begin
      bad++; $display("FAIL overlay_font_addr: got %h want %h", fa0, {7'h41, 3'd0});
    end
    for (int j = 0; j < 8; j++) begin
      exp_o = (j == 0) ? 15'h7FE0 : rgb(10,5,2);
      total++;
      if (outs[j] !== exp_o) begin
        bad++; $display("FAIL overlay_px%0d: got %h want %h", j, outs[j], exp_o);
      end
    end
  endtask

  task automatic test_window_edges();
    logic [9:0]  hs [7];
    logic [8:0]  vs [7];
    logic        ps [7];
    logic        ov [7];
    logic [14:0] c, o, exp_o;
    logic [9:0]  fa;
    hs = '{10'd31, 10'd288, 10'd32, 10'd32, 10'd32, 10'd287, 10'd32};
    vs = '{9'd96,  9'd96,   9'd95,  9'd160, 9'd96,  9'd159,  9'd96};
    ps = '{1'b1,   1'b1,    1'b1,   1'b1,   1'b0,   1'b1,    1'b1};
    ov = '{1'b0,   1'b0,    1'b0,   1'b0,   1'b0,   1'b1,    1'b1};
    c  = rgb(31,0,17);
    cpu_write(8'd255, 8'h41);
    for (int k = 0; k < 7; k++) begin
      run_pixel(hs[k], vs[k], ps[k], 1'b0, c, o, fa);
      exp_o = ov[k] ? 15'h7FE0 : c;
      total++;
      if (o !== exp_o) begin
        bad++; $display("FAIL edge_h%0d_v%0d: got %h want %h", hs[k], vs[k], o, exp_o);
      end
      if (k == 5) begin
        total++;
        if (fa !== {7'h41, 3'd7}) begin
          bad++; $display("FAIL edge_font_addr: got %h want %h", fa, {7'h41, 3'd7});
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0][14:0] outs;
    logic [9:0]       fa0;
    logic [14:0]      exp_o;
    cpu_write(8'd1, 8'hC1);
    for (int bl = 0; bl < 2; bl++) begin
      run_stream(10'd40, 9'd96, bl[0], rgb(20,10,4), outs, fa0);
      for (int j = 0; j < 8; j++) begin
        exp_o = ((j == 0) ^ (bl == 1)) ? 15'h7FE0 : rgb(10,5,2);
        total++;
        if (outs[j] !== exp_o) begin
          bad++; $display("FAIL blink%0d_px%0d: got %h want %h", bl, j, outs[j], exp_o);
        end
      end
    end
  endtask

  task automatic test_clear();
    int          n;
    logic [14:0] o;
    logic [9:0]  fa;
    ctrl_write(8'h03);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL clear_busy_start: got %b want 1", bus.busy);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (n == 10) begin
        bus.wr = 1'b1; bus.addr = 8'd5; bus.d = 8'h41;
      end
      @(posedge clk); #1;
      bus.wr = 1'b0;
      n++;
    end
    total++;
    if (n != 256) begin
      bad++; $display("FAIL clear_length: got %0d want 256", n);
    end
    for (int a = 0; a < 256; a++) begin
      run_pixel(10'd32 + 10'(8 * (a % 32)), 9'd96 + 9'(8 * (a / 32)), 1'b1, 1'b0,
                rgb(20,10,4), o, fa);
      total++;
      if (fa[9:3] !== 7'h20 || o !== rgb(10,5,2)) begin
        bad++; $display("FAIL clear_cell%0d: got code %h out %h want code 20 out %h",
                        a, fa[9:3], o, rgb(10,5,2));
      end
    end
    ctrl_write(8'h03);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (n == 99) begin
        bus.ctrl_wr = 1'b1; bus.d = 8'h03;
      end
      @(posedge clk); #1;
      bus.ctrl_wr = 1'b0;
      n++;
    end
    total++;
    if (n != 356) begin
      bad++; $display("FAIL clear_restart_length: got %0d want 356", n);
    end
  endtask

  task automatic test_reset_mid();
    ctrl_write(8'h03);
    set_pix(10'd0, 9'd0, 1'b1, 1'b0, rgb(7,7,7));
    repeat (3) step_ce();
    total++;
    if (bus.busy !== 1'b1 || cur_out() !== rgb(7,7,7)) begin
      bad++; $display("FAIL midreset_pre: got busy %b out %h want busy 1 out %h",
                      bus.busy, cur_out(), rgb(7,7,7));
    end
    #3 res = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy);
    end
    total++;
    if (cur_out() !== 15'd0) begin
      bad++; $display("FAIL midreset_out: got %h want 0000", cur_out());
    end
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    set_pix(10'd32, 9'd96, 1'b1, 1'b0, rgb(1,2,3));
    repeat (2) step_ce();
    total++;
    if (cur_out() !== 15'd0) begin
      bad++; $display("FAIL postreset_early: got %h want 0000", cur_out());
    end
    step_ce();
    total++;
    if (cur_out() !== rgb(1,2,3)) begin
      bad++; $display("FAIL postreset_pass: got %h want %h", cur_out(), rgb(1,2,3));
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL postreset_busy: got %b want 0", bus.busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    res     = 1'b1;
    bus.ce  = 1'b0;
    bus.wr  = 1'b0;
    bus.ctrl_wr = 1'b0;
    bus.addr = 8'd0;
    bus.d    = 8'd0;
    set_pix(10'd0, 9'd0, 1'b0, 1'b0, 15'd0);
    test_reset();
    test_passthrough();
    test_overlay_text();
    test_window_edges();
    test_blink();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
